// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between instruction fetch (read-only) and data stage (read/write).
// One access in flight at a time; data normally wins, a starvation counter forces fetch progress.
module mem_arbiter #(
   parameter int unsigned AW     = 16,
   parameter int unsigned DW     = 16,
   parameter int unsigned LAT    = 1,
   parameter int unsigned STARVE = 4
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          if_req,
   input  logic [AW-1:0] if_addr,
   output logic          if_ack,
   output logic [DW-1:0] if_rdata,
   input  logic          d_req,
   input  logic          d_we,
   input  logic [AW-1:0] d_addr,
   input  logic [DW-1:0] d_wdata,
   output logic          d_ack,
   output logic [DW-1:0] d_rdata,
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   output logic          busy
);

   localparam logic [1:0] LAT_C    = 2'(LAT);
   localparam logic [3:0] STARVE_C = 4'(STARVE);

   typedef enum logic {
      ST_IDLE,
      ST_WAIT
   } state_t;

   state_t     state_q, state_d;
   logic       gnt_q, gnt_d;
   logic       gwe_q, gwe_d;
   logic [1:0] cnt_q, cnt_d;
   logic [3:0] starve_q, starve_d;
   logic       win_data;

   always_comb begin
      state_d   = state_q;
      gnt_d     = gnt_q;
      gwe_d     = gwe_q;
      cnt_d     = cnt_q;
      starve_d  = starve_q;
      win_data  = 1'b0;
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      if_ack    = 1'b0;
      d_ack     = 1'b0;
      if_rdata  = '0;
      d_rdata   = '0;

      case (state_q)
         ST_IDLE: begin
            // Issue is suppressed while reset is high so no stray write reaches the memory.
            if (!reset && (if_req || d_req)) begin
               win_data  = d_req && (!if_req || (starve_q < STARVE_C));
               mem_en    = 1'b1;
               mem_we    = win_data && d_we;
               mem_addr  = win_data ? d_addr : if_addr;
               mem_wdata = (win_data && d_we) ? d_wdata : '0;
               gnt_d     = win_data;
               gwe_d     = win_data && d_we;
               cnt_d     = (win_data && d_we) ? 2'd1 : LAT_C;
               state_d   = ST_WAIT;
               if (!win_data) begin
                  starve_d = '0;
               end else if (if_req) begin
                  starve_d = starve_q + 4'd1;
               end
            end
         end
         ST_WAIT: begin
            if (cnt_q == 2'd1) begin
               state_d = ST_IDLE;
               if (!reset) begin
                  if (gnt_q) begin
                     d_ack   = 1'b1;
                     d_rdata = gwe_q ? '0 : mem_rdata;
                  end else begin
                     if_ack   = 1'b1;
                     if_rdata = mem_rdata;
                  end
               end
            end else begin
               cnt_d = cnt_q - 2'd1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         gnt_q    <= 1'b0;
         gwe_q    <= 1'b0;
         cnt_q    <= '0;
         starve_q <= '0;
      end else begin
         state_q  <= state_d;
         gnt_q    <= gnt_d;
         gwe_q    <= gwe_d;
         cnt_q    <= cnt_d;
         starve_q <= starve_d;
      end
   end

   assign busy = (state_q == ST_WAIT);

endmodule
